// File: rtl/uart_pkg.sv
// Shared UART types and helpers: TX state encoding, parity mode codes and
// the clocks-per-bit calculation used by the TX (and later RX) blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int cycles_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CYCLES_PER_BIT-1 while enabled and pulses
// o_tick for one cycle on the terminal count. i_clear restarts the period.
module uart_baud_tick #(
  parameter int CYCLES_PER_BIT = 10
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int W = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [W-1:0] TERM = W'(CYCLES_PER_BIT - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == TERM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter, valid/ready input, LSB-first serial output.
// Define UART_TX_HOLD_EN to add a one-word holding register for gapless frames.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 125000000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 UART_TX
);

  localparam int CPB = cycles_per_bit(CLK_FREQ, BAUD);

  if (DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
      CPB < 2 || PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD) begin : g_param_err
    $error("uart_tx_param: illegal parameter set");
  end

  uart_tx_state_t       r_state, w_state_next;
  logic                 r_tx, w_tx_next;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [3:0]           r_idx, w_idx_next;
  logic                 w_load, w_from_hold, w_shift, w_xfer, w_tick, w_en;
  logic                 w_hold_avail;
  logic [DATA_BITS-1:0] w_hold_data, w_load_data;

  assign w_xfer      = tx_valid && tx_ready;
  assign w_en        = (r_state != IDLE);
  assign busy        = (r_state != IDLE);
  assign UART_TX     = r_tx;
  assign w_load_data = w_from_hold ? w_hold_data : tx_data;

`ifdef UART_TX_HOLD_EN
  logic                 r_hold_valid;
  logic [DATA_BITS-1:0] r_hold_data;
  logic                 w_hold_push;

  assign tx_ready     = !r_hold_valid;
  assign w_hold_avail = r_hold_valid;
  assign w_hold_data  = r_hold_data;
  // A word accepted on the same edge it is loaded into the shifter bypasses the hold register.
  assign w_hold_push  = w_xfer && !(w_load && !w_from_hold);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (w_hold_push) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= tx_data;
    end else if (w_load && w_from_hold) begin
      r_hold_valid <= 1'b0;
    end
  end
`else
  assign tx_ready     = (r_state == IDLE);
  assign w_hold_avail = 1'b0;
  assign w_hold_data  = '0;
`endif

  uart_baud_tick #(.CYCLES_PER_BIT(CPB)) u_baud (
    .i_clk   (sysclk),
    .i_rst_n (rst_n),
    .i_clear (w_load),
    .i_en    (w_en),
    .o_tick  (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_tx_next    = r_tx;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    w_from_hold  = 1'b0;
    w_shift      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_hold_avail || w_xfer) begin
          w_load       = 1'b1;
          w_from_hold  = w_hold_avail;
          w_state_next = START;
          w_tx_next    = 1'b0;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_next = DATA;
          w_tx_next    = r_shift[0];
          w_idx_next   = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_idx == 4'(DATA_BITS - 1)) begin
            w_idx_next = '0;
            if (PARITY_MODE != PARITY_NONE) begin
              w_state_next = PARITY;
              w_tx_next    = r_parity;
            end else begin
              w_state_next = STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_idx_next = r_idx + 4'd1;
            w_shift    = 1'b1;
            w_tx_next  = r_shift[1];
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_next = STOP;
          w_tx_next    = 1'b1;
          w_idx_next   = '0;
        end
      end
      STOP: begin
        if (w_tick) begin
          if (r_idx == 4'(STOP_BITS - 1)) begin
            // Chaining only happens with the hold register; base build never accepts here.
            if (w_hold_avail || w_xfer) begin
              w_load       = 1'b1;
              w_from_hold  = w_hold_avail;
              w_state_next = START;
              w_tx_next    = 1'b0;
            end else begin
              w_state_next = IDLE;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_idx_next = r_idx + 4'd1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_idx    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tx    <= w_tx_next;
      r_idx   <= w_idx_next;
      if (w_load) begin
        r_shift  <= w_load_data;
        r_parity <= (^w_load_data) ^ (PARITY_MODE == PARITY_ODD);
      end else if (w_shift) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four configurations (8N1, 8E1, 8O1,
// 7N2) at 10 clocks/bit, line compared cycle-by-cycle against frames built here.
module tb_uart_tx_param;

  localparam int CPB  = 10;
  localparam int NDUT = 4;
`ifdef UART_TX_HOLD_EN
  localparam bit EXP_RDY_BUSY = 1'b1;
`else
  localparam bit EXP_RDY_BUSY = 1'b0;
`endif

  logic       sysclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic [8:0] r_data  [NDUT];
  logic       r_valid [NDUT];
  logic       w_ready [NDUT];
  logic       w_busy  [NDUT];
  logic       w_line  [NDUT];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 sysclk = ~sysclk;

  uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .sysclk(sysclk), .rst_n(rst_n), .tx_data(r_data[0][7:0]), .tx_valid(r_valid[0]),
    .tx_ready(w_ready[0]), .busy(w_busy[0]), .UART_TX(w_line[0]));
  uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .sysclk(sysclk), .rst_n(rst_n), .tx_data(r_data[1][7:0]), .tx_valid(r_valid[1]),
    .tx_ready(w_ready[1]), .busy(w_busy[1]), .UART_TX(w_line[1]));
  uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
    .sysclk(sysclk), .rst_n(rst_n), .tx_data(r_data[2][7:0]), .tx_valid(r_valid[2]),
    .tx_ready(w_ready[2]), .busy(w_busy[2]), .UART_TX(w_line[2]));
  uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u3 (
    .sysclk(sysclk), .rst_n(rst_n), .tx_data(r_data[3][6:0]), .tx_valid(r_valid[3]),
    .tx_ready(w_ready[3]), .busy(w_busy[3]), .UART_TX(w_line[3]));

  function automatic int db_of(input int d);
    return (d == 3) ? 7 : 8;
  endfunction
  function automatic int pm_of(input int d);
    return (d == 1) ? 1 : (d == 2) ? 2 : 0;
  endfunction
  function automatic int sb_of(input int d);
    return (d == 3) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Bit sequence of one frame: start, data LSB first, optional parity, stop bits.
  function automatic int build_frame(input int d, input logic [8:0] w, output logic [15:0] bits);
    int   n = 0;
    logic p = 1'b0;
    bits = '1;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < db_of(d); i++) begin
      bits[n] = w[i];
      p ^= w[i];
      n++;
    end
    if (pm_of(d) == 1) begin bits[n] = p;  n++; end
    if (pm_of(d) == 2) begin bits[n] = ~p; n++; end
    for (int i = 0; i < sb_of(d); i++) begin bits[n] = 1'b1; n++; end
    return n;
  endfunction

  task automatic check_idle(input int d, input string tag);
    check($sformatf("u%0d_%s_line", d, tag), w_line[d], 1);
    check($sformatf("u%0d_%s_busy", d, tag), w_busy[d], 0);
    check($sformatf("u%0d_%s_rdy", d, tag), w_ready[d], 1);
  endtask

  task automatic run_frame(input int d, input logic [8:0] w, input bit corrupt);
    logic [15:0] bits;
    int          n;
    int unsigned bad_line = 0, bad_busy = 0, bad_rdy = 0;
    n = build_frame(d, w, bits);
    @(negedge sysclk);
    check($sformatf("u%0d_rdy_pre", d), w_ready[d], 1);
    r_data[d]  = w;
    r_valid[d] = 1'b1;
    @(posedge sysclk);
    #1;
    r_valid[d] = 1'b0;
    if (corrupt) r_data[d] = ~w;
    for (int k = 0; k < n * CPB; k++) begin
      @(negedge sysclk);
      if (w_line[d] !== bits[k / CPB]) bad_line++;
      if (w_busy[d] !== 1'b1) bad_busy++;
      if (w_ready[d] !== EXP_RDY_BUSY) bad_rdy++;
    end
    check($sformatf("u%0d_frame_line_%03h", d, w), bad_line, 0);
    check($sformatf("u%0d_frame_busy_%03h", d, w), bad_busy, 0);
    check($sformatf("u%0d_frame_rdy_%03h", d, w), bad_rdy, 0);
    @(negedge sysclk);
    check_idle(d, "post");
  endtask

  task automatic back_to_back();
    logic [15:0] b1, b2, b3;
    logic [8:0]  w1, w2, w3;
    logic        exp_line, exp_busy, exp_rdy;
    int          f;
    int unsigned bad_line = 0, bad_busy = 0, bad_rdy = 0, idle_cycles = 0;
    w1 = 9'($urandom);
    w2 = 9'($urandom);
    w3 = 9'($urandom);
    f = build_frame(0, w1, b1) * CPB;
    void'(build_frame(0, w2, b2));
    void'(build_frame(0, w3, b3));
    @(negedge sysclk);
    r_data[0]  = w1;
    r_valid[0] = 1'b1;
    @(posedge sysclk);
    #1;
    r_data[0] = w2;
`ifdef UART_TX_HOLD_EN
    for (int k = 0; k < 3 * f; k++) begin
      @(negedge sysclk);
      exp_line = (k < f) ? b1[k / CPB] : (k < 2 * f) ? b2[(k - f) / CPB] : b3[(k - 2 * f) / CPB];
      exp_busy = 1'b1;
      exp_rdy  = (k == 0) || (k == f) || (k >= 2 * f);
      if (w_line[0] !== exp_line) bad_line++;
      if (w_busy[0] !== exp_busy) bad_busy++;
      if (w_ready[0] !== exp_rdy) bad_rdy++;
      if (w_busy[0] !== 1'b1) idle_cycles++;
      if (k == 1) r_data[0] = w3;
      if (k == f + 1) r_valid[0] = 1'b0;
    end
    check("b2b_idle_cycles", idle_cycles, 0);
`else
    for (int k = 0; k < 2 * f + 1; k++) begin
      @(negedge sysclk);
      exp_line = (k < f) ? b1[k / CPB] : (k == f) ? 1'b1 : b2[(k - f - 1) / CPB];
      exp_busy = (k != f);
      exp_rdy  = (k == f);
      if (w_line[0] !== exp_line) bad_line++;
      if (w_busy[0] !== exp_busy) bad_busy++;
      if (w_ready[0] !== exp_rdy) bad_rdy++;
      if (w_busy[0] !== 1'b1) idle_cycles++;
      if (k == f + 1) r_valid[0] = 1'b0;
    end
    check("b2b_idle_cycles", idle_cycles, 1);
`endif
    check("b2b_line", bad_line, 0);
    check("b2b_busy", bad_busy, 0);
    check("b2b_rdy", bad_rdy, 0);
    @(negedge sysclk);
    check_idle(0, "b2b_post");
  endtask

  task automatic reset_mid_frame();
    @(negedge sysclk);
    r_data[0]  = 9'h0A5;
    r_valid[0] = 1'b1;
    @(posedge sysclk);
    #1;
    r_valid[0] = 1'b0;
    repeat (45) @(negedge sysclk);
    check("rst_mid_line_before", w_line[0], 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle(0, "rst_async");
    @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    check_idle(0, "rst_release");
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      r_data[d]  = '0;
      r_valid[d] = 1'b0;
    end
    repeat (3) @(negedge sysclk);
    for (int d = 0; d < NDUT; d++) check_idle(d, "reset");
    rst_n = 1'b1;
    @(negedge sysclk);

    run_frame(0, 9'h041, 1'b0);
    run_frame(1, 9'h007, 1'b0);
    run_frame(2, 9'h007, 1'b0);
    run_frame(3, 9'h07F, 1'b0);
    run_frame(1, 9'h05A, 1'b1);
    run_frame(2, 9'h03C, 1'b1);
    run_frame(0, 9'h0C3, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < NDUT; d++) run_frame(d, 9'($urandom), ($urandom % 2) == 1);
    end

    back_to_back();
    reset_mid_frame();
    run_frame(0, 9'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
